// File: rtl/gnr_attractor_ctrl.sv
// gnr_attractor_ctrl: sweeps a range of initial states through the GRN node
// array, finds each trajectory's attractor with tortoise/hare detection, then
// measures the attractor period. It streams one result per initial state
// through a valid/ready handshake.
module gnr_attractor_ctrl #(
  parameter int N_NODES   = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] init_base,
  input  logic [N_NODES:0]   init_count,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N_NODES-1:0] res_init,
  output logic [N_NODES-1:0] res_state,
  output logic [CNT_W-1:0]   res_steps,
  output logic [CNT_W-1:0]   res_period,
  output logic               res_timeout,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FIND, S_PERIOD, S_RESULT, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] K_MAX = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] P_MAX = '1;

  state_t             state_q, state_d;
  logic [N_NODES-1:0] cur_q, cur_d;
  logic [N_NODES:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0]   p_q, p_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [N_NODES-1:0] res_init_q, res_init_d;
  logic [N_NODES-1:0] res_state_q, res_state_d;
  logic [CNT_W-1:0]   res_steps_q, res_steps_d;
  logic [CNT_W-1:0]   res_period_q, res_period_d;
  logic               res_timeout_q, res_timeout_d;

  logic vec_eq;
  logic find_match;
  logic period_hit;

  assign vec_eq     = (s0_vec == s1_vec);
  // k=1 always compares equal (both copies took exactly one step), so need k>=2
  assign find_match = vec_eq && (k_q >= CNT_W'(2));
  assign period_hit = vec_eq && (p_q != '0);

  assign init_state  = cur_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign res_init    = res_init_q;
  assign res_state   = res_state_q;
  assign res_steps   = res_steps_q;
  assign res_period  = res_period_q;
  assign res_timeout = res_timeout_q;

  // Next-state, counter/result updates and strobe decode
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    remaining_d   = remaining_q;
    k_d           = k_q;
    p_d           = p_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    res_init_d    = res_init_q;
    res_state_d   = res_state_q;
    res_steps_d   = res_steps_q;
    res_period_d  = res_period_q;
    res_timeout_d = res_timeout_q;
    reset_nos     = 1'b0;
    start_s0      = 1'b0;
    start_s1      = 1'b0;
    res_valid     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d       = init_base;
          remaining_d = init_count;
          busy_d      = 1'b1;
          state_d     = (init_count == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        reset_nos     = 1'b1;
        k_d           = '0;
        p_d           = '0;
        res_init_d    = cur_q;
        res_timeout_d = 1'b0;
        state_d       = S_FIND;
      end
      S_FIND: begin
        if (find_match) begin
          res_steps_d = k_q;
          state_d     = S_PERIOD;
        end else if (k_q == K_MAX) begin
          res_steps_d   = k_q;
          res_state_d   = s0_vec;
          res_period_d  = '0;
          res_timeout_d = 1'b1;
          state_d       = S_RESULT;
        end else begin
          start_s0 = 1'b1;
          start_s1 = 1'b1;
          k_d      = k_q + 1'b1;
        end
      end
      S_PERIOD: begin
        // s0 stays frozen on the detected attractor point; only s1 walks
        if (period_hit) begin
          res_state_d   = s0_vec;
          res_period_d  = p_q;
          res_timeout_d = 1'b0;
          state_d       = S_RESULT;
        end else begin
          start_s1 = 1'b1;
          if (p_q == P_MAX) begin
            res_state_d   = s0_vec;
            res_period_d  = '0;
            res_timeout_d = 1'b1;
            state_d       = S_RESULT;
          end else begin
            p_d = p_q + 1'b1;
          end
        end
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          cur_d       = cur_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          state_d     = (remaining_q > (N_NODES+1)'(1)) ? S_LOAD : S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_q         <= '0;
      remaining_q   <= '0;
      k_q           <= '0;
      p_q           <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      res_init_q    <= '0;
      res_state_q   <= '0;
      res_steps_q   <= '0;
      res_period_q  <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      remaining_q   <= remaining_d;
      k_q           <= k_d;
      p_q           <= p_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      res_init_q    <= res_init_d;
      res_state_q   <= res_state_d;
      res_steps_q   <= res_steps_d;
      res_period_q  <= res_period_d;
      res_timeout_q <= res_timeout_d;
    end
  end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: behavioural 3-node network driven by a
// programmable next-state table, fixed scenarios plus randomized sweeps
// scored against an arithmetic attractor model.
module tb_gnr_attractor_ctrl;

  localparam int N  = 3;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [N-1:0] flut [8];

  int n_tests = 0;
  int n_fail  = 0;
  int excl_viol = 0;

  function automatic logic [N-1:0] f(input logic [N-1:0] x);
    return flut[x];
  endfunction

  // DUT A: default step limit
  logic          a_start, a_res_ready;
  logic [N-1:0]  a_base;
  logic [N:0]    a_count;
  logic [N-1:0]  a_s0, a_s1, a_init_state, a_res_init, a_res_state;
  logic          a_reset_nos, a_start_s0, a_start_s1, a_res_valid, a_res_timeout, a_busy, a_done;
  logic [CW-1:0] a_res_steps, a_res_period;

  // DUT B: step limit of 8
  logic          b_start, b_res_ready;
  logic [N-1:0]  b_base;
  logic [N:0]    b_count;
  logic [N-1:0]  b_s0, b_s1, b_init_state, b_res_init, b_res_state;
  logic          b_reset_nos, b_start_s0, b_start_s1, b_res_valid, b_res_timeout, b_busy, b_done;
  logic [CW-1:0] b_res_steps, b_res_period;

  gnr_attractor_ctrl #(.N_NODES(N), .CNT_W(CW), .MAX_STEPS(4096)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .init_base(a_base), .init_count(a_count),
    .s0_vec(a_s0), .s1_vec(a_s1), .reset_nos(a_reset_nos), .init_state(a_init_state),
    .start_s0(a_start_s0), .start_s1(a_start_s1), .res_valid(a_res_valid), .res_ready(a_res_ready),
    .res_init(a_res_init), .res_state(a_res_state), .res_steps(a_res_steps), .res_period(a_res_period),
    .res_timeout(a_res_timeout), .busy(a_busy), .done(a_done));

  gnr_attractor_ctrl #(.N_NODES(N), .CNT_W(CW), .MAX_STEPS(8)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .init_base(b_base), .init_count(b_count),
    .s0_vec(b_s0), .s1_vec(b_s1), .reset_nos(b_reset_nos), .init_state(b_init_state),
    .start_s0(b_start_s0), .start_s1(b_start_s1), .res_valid(b_res_valid), .res_ready(b_res_ready),
    .res_init(b_res_init), .res_state(b_res_state), .res_steps(b_res_steps), .res_period(b_res_period),
    .res_timeout(b_res_timeout), .busy(b_busy), .done(b_done));

  // Node arrays: s1 steps on every start_s1, s0 on every second start_s0 (first one included)
  logic na_pass = 1'b0, nb_pass = 1'b0;
  initial begin a_s0 = '0; a_s1 = '0; b_s0 = '0; b_s1 = '0; end
  always @(posedge clk) begin
    if (a_reset_nos) begin
      a_s0 <= a_init_state; a_s1 <= a_init_state; na_pass <= 1'b1;
    end else begin
      if (a_start_s1) a_s1 <= f(a_s1);
      if (a_start_s0) begin
        if (na_pass) a_s0 <= f(a_s0);
        na_pass <= ~na_pass;
      end
    end
  end
  always @(posedge clk) begin
    if (b_reset_nos) begin
      b_s0 <= b_init_state; b_s1 <= b_init_state; nb_pass <= 1'b1;
    end else begin
      if (b_start_s1) b_s1 <= f(b_s1);
      if (b_start_s0) begin
        if (nb_pass) b_s0 <= f(b_s0);
        nb_pass <= ~nb_pass;
      end
    end
  end

  // Load strobe must never overlap a step strobe; s0 never steps without s1
  always @(negedge clk) begin
    if (!rst) begin
      if (a_reset_nos && (a_start_s0 || a_start_s1)) excl_viol++;
      if (b_reset_nos && (b_start_s0 || b_start_s1)) excl_viol++;
      if (a_start_s0 && !a_start_s1) excl_viol++;
      if (b_start_s0 && !b_start_s1) excl_viol++;
    end
  end

  // Captured results of the last sweep on DUT A
  int            g_n;
  logic [N-1:0]  g_init [16];
  logic [N-1:0]  g_state [16];
  logic [CW-1:0] g_steps [16];
  logic [CW-1:0] g_period [16];
  logic          g_to [16];

  // Attractor model: after k strobes the fast copy is f^k(x), the slow copy f^ceil(k/2)(x)
  task automatic ref_model(input logic [N-1:0] x, input int maxs, output logic [CW-1:0] steps,
                           output logic [CW-1:0] period, output logic [N-1:0] st, output logic to);
    logic [N-1:0] slow, fast, y;
    int p;
    slow = x; fast = x; to = 1'b1; steps = CW'(maxs); period = '0; st = '0;
    for (int k = 1; k <= maxs; k++) begin
      fast = f(fast);
      if (k % 2 == 1) slow = f(slow);
      if (k >= 2 && slow == fast) begin
        to = 1'b0; steps = CW'(k); st = slow;
        y = f(slow); p = 1;
        while (y != slow && p < 64) begin y = f(y); p++; end
        period = CW'(p);
        break;
      end
    end
  endtask

  task automatic run_a(input logic [N-1:0] base, input logic [N:0] count, input int ready_pct,
                       input string name);
    int cyc = 0;
    logic seen_done = 1'b0;
    logic hold = 1'b0;
    logic [38:0] snap = '0;
    g_n = 0;
    @(negedge clk); a_base = base; a_count = count; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    n_tests++;
    if (a_busy !== 1'b1) begin
      n_fail++; $display("FAIL %s_busy: got %0b expected 1", name, a_busy);
    end
    while (cyc < 3000) begin
      if (a_done === 1'b1) begin seen_done = 1'b1; break; end
      if (hold) begin
        n_tests++;
        if (a_res_valid !== 1'b1 ||
            {a_res_init, a_res_state, a_res_steps, a_res_period, a_res_timeout} !== snap) begin
          n_fail++;
          $display("FAIL %s_stable: got valid=%0b res=%0h expected valid=1 res=%0h", name, a_res_valid,
                   {a_res_init, a_res_state, a_res_steps, a_res_period, a_res_timeout}, snap);
        end
      end
      a_res_ready = ($urandom_range(99) < ready_pct);
      if (a_res_valid === 1'b1 && a_res_ready) begin
        if (g_n < 16) begin
          g_init[g_n] = a_res_init; g_state[g_n] = a_res_state; g_steps[g_n] = a_res_steps;
          g_period[g_n] = a_res_period; g_to[g_n] = a_res_timeout;
        end
        g_n++;
      end
      hold = (a_res_valid === 1'b1) && !a_res_ready;
      snap = {a_res_init, a_res_state, a_res_steps, a_res_period, a_res_timeout};
      @(negedge clk); cyc++;
    end
    a_res_ready = 1'b0;
    n_tests++;
    if (!seen_done) begin
      n_fail++; $display("FAIL %s_done_timeout: got no done within %0d cycles expected done", name, cyc);
    end
    n_tests++;
    if (g_n != int'(count)) begin
      n_fail++; $display("FAIL %s_count: got %0d results expected %0d", name, g_n, count);
    end
    if (seen_done) begin
      n_tests++;
      if (a_busy !== 1'b0 || a_res_valid !== 1'b0) begin
        n_fail++; $display("FAIL %s_done_cycle: got busy=%0b valid=%0b expected 0 0", name, a_busy, a_res_valid);
      end
      @(negedge clk);
      n_tests++;
      if (a_done !== 1'b0 || a_busy !== 1'b0) begin
        n_fail++; $display("FAIL %s_done_pulse: got done=%0b busy=%0b expected 0 0", name, a_done, a_busy);
      end
    end
  endtask

  task automatic check_result(input int i, input logic [N-1:0] init, input logic [N-1:0] st,
                              input int steps, input int period, input logic to, input logic chk_state,
                              input string name);
    n_tests++;
    if (g_init[i] !== init || g_steps[i] !== CW'(steps) || g_period[i] !== CW'(period) || g_to[i] !== to ||
        (chk_state && g_state[i] !== st)) begin
      n_fail++;
      $display("FAIL %s[%0d]: got init=%0d state=%0d steps=%0d period=%0d to=%0b expected %0d %0d %0d %0d %0b",
               name, i, g_init[i], g_state[i], g_steps[i], g_period[i], g_to[i], init, st, steps, period, to);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({a_busy, a_res_valid, a_reset_nos, a_start_s0, a_start_s1, a_done, b_busy, b_res_valid} !== 8'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %0b expected 0",
                         {a_busy, a_res_valid, a_reset_nos, a_start_s0, a_start_s1, a_done, b_busy, b_res_valid});
    end
    n_tests++;
    if (a_init_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_init_state: got %0d expected 0", a_init_state);
    end
    n_tests++;
    if ({a_res_init, a_res_state, a_res_steps, a_res_period, a_res_timeout} !== 39'd0) begin
      n_fail++; $display("FAIL reset_results: got %0h expected 0",
                         {a_res_init, a_res_state, a_res_steps, a_res_period, a_res_timeout});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    for (int i = 0; i < 8; i++) flut[i] = 3'(i);
    run_a(3'd5, 4'd1, 100, "identity");
    check_result(0, 3'd5, 3'd5, 2, 1, 1'b0, 1'b1, "identity");
  endtask

  task automatic test_const_zero();
    for (int i = 0; i < 8; i++) flut[i] = 3'd0;
    run_a(3'd5, 4'd1, 100, "const0");
    check_result(0, 3'd5, 3'd0, 2, 1, 1'b0, 1'b1, "const0");
  endtask

  task automatic test_increment();
    for (int i = 0; i < 8; i++) flut[i] = 3'(i + 1);
    run_a(3'd0, 4'd8, 100, "incr");
    for (int i = 0; i < 8; i++) check_result(i, 3'(i), 3'(i), 16, 8, 1'b0, 1'b0, "incr");
  endtask

  task automatic test_max_steps();
    int cyc = 0;
    logic [38:0] snap;
    for (int i = 0; i < 8; i++) flut[i] = 3'(i + 1);
    @(negedge clk); b_base = 3'd0; b_count = 4'd1; b_start = 1'b1; b_res_ready = 1'b0;
    @(negedge clk); b_start = 1'b0;
    while (b_res_valid !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    n_tests++;
    if (b_res_valid !== 1'b1) begin
      n_fail++; $display("FAIL maxsteps_valid: got %0b expected 1", b_res_valid);
    end
    n_tests++;
    if (b_res_steps !== 16'd8 || b_res_timeout !== 1'b1 || b_res_period !== 16'd0 || b_res_init !== 3'd0) begin
      n_fail++; $display("FAIL maxsteps_result: got steps=%0d to=%0b period=%0d init=%0d expected 8 1 0 0",
                         b_res_steps, b_res_timeout, b_res_period, b_res_init);
    end
    snap = {b_res_init, b_res_state, b_res_steps, b_res_period, b_res_timeout};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (b_res_valid !== 1'b1 || {b_res_init, b_res_state, b_res_steps, b_res_period, b_res_timeout} !== snap) begin
        n_fail++; $display("FAIL maxsteps_hold[%0d]: got valid=%0b res=%0h expected 1 %0h", i, b_res_valid,
                           {b_res_init, b_res_state, b_res_steps, b_res_period, b_res_timeout}, snap);
      end
    end
    b_res_ready = 1'b1;
    @(negedge clk); b_res_ready = 1'b0;
    cyc = 0;
    while (b_done !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
    n_tests++;
    if (b_done !== 1'b1 || b_busy !== 1'b0) begin
      n_fail++; $display("FAIL maxsteps_done: got done=%0b busy=%0b expected 1 0", b_done, b_busy);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) flut[i] = 3'(i);
    run_a(3'd7, 4'd2, 60, "wrap");
    check_result(0, 3'd7, 3'd7, 2, 1, 1'b0, 1'b1, "wrap");
    check_result(1, 3'd0, 3'd0, 2, 1, 1'b0, 1'b1, "wrap");
  endtask

  task automatic test_count_zero();
    @(negedge clk); a_base = 3'd4; a_count = 4'd0; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    n_tests++;
    if (a_done !== 1'b0 || a_res_valid !== 1'b0 || a_reset_nos !== 1'b0) begin
      n_fail++; $display("FAIL count0_cycle1: got done=%0b valid=%0b load=%0b expected 0 0 0",
                         a_done, a_res_valid, a_reset_nos);
    end
    @(negedge clk);
    n_tests++;
    if (a_done !== 1'b1 || a_res_valid !== 1'b0) begin
      n_fail++; $display("FAIL count0_cycle2: got done=%0b valid=%0b expected 1 0", a_done, a_res_valid);
    end
    @(negedge clk);
    n_tests++;
    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL count0_after: got done=%0b busy=%0b expected 0 0", a_done, a_busy);
    end
  endtask

  task automatic test_rst_mid();
    int cyc = 0;
    for (int i = 0; i < 8; i++) flut[i] = 3'(i + 1);
    @(negedge clk); a_base = 3'd0; a_count = 4'd8; a_start = 1'b1; a_res_ready = 1'b1;
    @(negedge clk); a_start = 1'b0;
    while (a_start_s0 !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    repeat (3) @(negedge clk);
    n_tests++;
    if (a_start_s0 !== 1'b1 || a_busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_in_find: got s0=%0b busy=%0b expected 1 1", a_start_s0, a_busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; a_res_ready = 1'b0;
    n_tests++;
    if ({a_start_s0, a_start_s1, a_reset_nos, a_busy, a_res_valid, a_done} !== 6'd0) begin
      n_fail++; $display("FAIL rstmid_abort: got %0b expected 0",
                         {a_start_s0, a_start_s1, a_reset_nos, a_busy, a_res_valid, a_done});
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_nodone: got done=%0b busy=%0b expected 0 0", a_done, a_busy);
    end
    run_a(3'd2, 4'd1, 100, "rstmid_rerun");
    check_result(0, 3'd2, 3'd2, 16, 8, 1'b0, 1'b0, "rstmid_rerun");
  endtask

  task automatic test_random();
    logic [N-1:0]  base, e_st;
    logic [N:0]    cnt;
    logic [CW-1:0] e_steps, e_period;
    logic          e_to;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 8; i++) flut[i] = 3'($urandom_range(7));
      base = 3'($urandom_range(7));
      cnt  = 4'($urandom_range(8, 1));
      run_a(base, cnt, 50, "random");
      for (int r = 0; r < int'(cnt) && r < g_n; r++) begin
        ref_model(3'(base + 3'(r)), 4096, e_steps, e_period, e_st, e_to);
        check_result(r, 3'(base + 3'(r)), e_st, int'(e_steps), int'(e_period), e_to, 1'b1, "random");
      end
    end
  endtask

  task automatic test_exclusive();
    n_tests++;
    if (excl_viol != 0) begin
      n_fail++; $display("FAIL strobe_exclusive: got %0d violations expected 0", excl_viol);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_res_ready = 1'b0; a_base = '0; a_count = '0;
    b_start = 1'b0; b_res_ready = 1'b0; b_base = '0; b_count = '0;
    for (int i = 0; i < 8; i++) flut[i] = 3'(i);
    test_reset();
    test_identity();
    test_const_zero();
    test_increment();
    test_max_steps();
    test_wrap();
    test_count_zero();
    test_rst_mid();
    test_random();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
